// File: rtl/fll_cfg_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | fll_cfg_responder : responder for the four-phase FLL configuration
// |   handshake; holds three config words and returns a status word.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module fll_cfg_responder #(
  parameter int unsigned ACK_DLY  = 2,
  parameter logic [31:0] CFG1_RST = 32'h0000_0000,
  parameter logic [31:0] CFG2_RST = 32'h0000_0000,
  parameter logic [31:0] CFG3_RST = 32'h0000_0000
) (
  input  logic        ref_clk,
  input  logic        rst,
  input  logic        cfgreq,
  input  logic        cfgweb,
  input  logic [1:0]  cfgad,
  input  logic [31:0] cfgd,
  input  logic [31:0] status_in,
  output logic        cfgack,
  output logic [31:0] cfgq,
  output logic [31:0] cfg1_o,
  output logic [31:0] cfg2_o,
  output logic [31:0] cfg3_o,
  output logic        cfg_update
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] C_DLY = 4'(ACK_DLY);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        capture;
  logic        commit;

  logic [1:0]  r_ad;
  logic        r_web;
  logic [31:0] r_d;
  logic [31:0] w_rdata;
  logic        w_wr_commit;
  logic        w_rd_commit;

  // The commit edge is the one leaving WAIT with the counter already at zero,
  // which places acknowledge ACK_DLY+1 edges after the capture edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfgreq) begin
          capture   = 1'b1;
          cnt_nxt   = C_DLY;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_ACK: begin
        if (!cfgreq) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = status_in;
    case (r_ad)
      2'd1:    w_rdata = cfg1_o;
      2'd2:    w_rdata = cfg2_o;
      2'd3:    w_rdata = cfg3_o;
      default: w_rdata = status_in;
    endcase
  end

  assign w_wr_commit = commit & ~r_web;
  assign w_rd_commit = commit & r_web;

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      r_ad  <= 2'd0;
      r_web <= 1'b0;
      r_d   <= 32'd0;
    end else if (capture) begin
      r_ad  <= cfgad;
      r_web <= cfgweb;
      r_d   <= cfgd;
    end
  end

  // Address 0 writes are acknowledged but touch nothing.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      cfg1_o     <= CFG1_RST;
      cfg2_o     <= CFG2_RST;
      cfg3_o     <= CFG3_RST;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= w_wr_commit && (r_ad != 2'd0);
      if (w_wr_commit) begin
        case (r_ad)
          2'd1:    cfg1_o <= r_d;
          2'd2:    cfg2_o <= r_d;
          2'd3:    cfg3_o <= r_d;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      cfgack <= 1'b0;
      cfgq   <= 32'd0;
    end else begin
      cfgack <= (state_nxt == S_ACK);
      if (w_rd_commit) begin
        cfgq <= w_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fll_cfg_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_fll_cfg_responder : scoreboard bench for fll_cfg_responder with
// |   ACK_DLY=2 and ACK_DLY=0 instances.  Revision: 1.0
// +----------------------------------------------------------------------------
module tb_fll_cfg_responder;

  localparam logic [31:0] A_CFG2_RST = 32'hA5A5_0001;
  localparam logic [31:0] B_CFG1_RST = 32'h1111_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic        cfgweb;
  logic [1:0]  cfgad;
  logic [31:0] cfgd, status_in;

  logic        ack_a, ack_b, upd_a, upd_b;
  logic [31:0] q_a, q_b, c1_a, c2_a, c3_a, c1_b, c2_b, c3_b;

  always #5 clk = ~clk;

  fll_cfg_responder #(.ACK_DLY(2), .CFG1_RST(32'h0), .CFG2_RST(A_CFG2_RST), .CFG3_RST(32'h0)) dut_a (
    .ref_clk(clk), .rst(rst), .cfgreq(req_a), .cfgweb(cfgweb), .cfgad(cfgad), .cfgd(cfgd),
    .status_in(status_in), .cfgack(ack_a), .cfgq(q_a), .cfg1_o(c1_a), .cfg2_o(c2_a),
    .cfg3_o(c3_a), .cfg_update(upd_a));

  fll_cfg_responder #(.ACK_DLY(0), .CFG1_RST(B_CFG1_RST), .CFG2_RST(32'h0), .CFG3_RST(32'h0)) dut_b (
    .ref_clk(clk), .rst(rst), .cfgreq(req_b), .cfgweb(cfgweb), .cfgad(cfgad), .cfgd(cfgd),
    .status_in(status_in), .cfgack(ack_b), .cfgq(q_b), .cfg1_o(c1_b), .cfg2_o(c2_b),
    .cfg3_o(c3_b), .cfg_update(upd_b));

  // sel=0 observes the ACK_DLY=2 instance, sel=1 the ACK_DLY=0 instance.
  bit          sel = 1'b0;
  logic        m_ack, m_upd;
  logic [31:0] m_q, m_c1, m_c2, m_c3;
  always_comb begin
    m_ack = sel ? ack_b : ack_a;
    m_upd = sel ? upd_b : upd_a;
    m_q   = sel ? q_b   : q_a;
    m_c1  = sel ? c1_b  : c1_a;
    m_c2  = sel ? c2_b  : c2_a;
    m_c3  = sel ? c3_b  : c3_a;
  end

  typedef struct {
    logic [31:0] q;
    logic [31:0] c1, c2, c3;
    logic        upd;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mcfg[2][4];
  logic [31:0] mq[2];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mcfg[0][1] = 32'h0;  mcfg[0][2] = A_CFG2_RST; mcfg[0][3] = 32'h0;
    mcfg[1][1] = B_CFG1_RST; mcfg[1][2] = 32'h0;  mcfg[1][3] = 32'h0;
    mq[0] = 32'h0;
    mq[1] = 32'h0;
  endtask

  // Monitor: every rising acknowledge pops one expected commit.
  logic        prev_ack = 1'b0;
  logic [31:0] held_q   = 32'h0;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_ack && !prev_ack) begin
        if (sbq.size() == 0) begin
          check("unexpected_ack", 32'(m_ack), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("cfgq", m_q, e.q);
          check("cfg1", m_c1, e.c1);
          check("cfg2", m_c2, e.c2);
          check("cfg3", m_c3, e.c3);
          check("cfg_update", 32'(m_upd), 32'(e.upd));
          held_q = m_q;
        end
      end else begin
        check("update_idle", 32'(m_upd), 32'd0);
        if (m_ack && prev_ack) check("cfgq_stable", m_q, held_q);
      end
    end
    prev_ack = m_ack;
  end

  task automatic txn(input bit s, input bit web, input logic [1:0] ad, input logic [31:0] d,
                     input logic [31:0] st, input int hold);
    exp_t e;
    int   lat;
    sel = s; cfgweb = web; cfgad = ad; cfgd = d; status_in = st;
    e.upd = 1'b0;
    if (!web && ad != 2'd0) begin
      mcfg[s][ad] = d;
      e.upd = 1'b1;
    end else if (web) begin
      mq[s] = (ad == 2'd0) ? st : mcfg[s][ad];
    end
    e.q = mq[s]; e.c1 = mcfg[s][1]; e.c2 = mcfg[s][2]; e.c3 = mcfg[s][3];
    sbq.push_back(e);
    if (s) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      if (m_ack) break;
      lat++;
      cfgd = $urandom; cfgad = 2'($urandom); cfgweb = 1'($urandom);
      if (lat > 40) break;
    end
    check("latency", 32'(lat), s ? 32'd1 : 32'd3);
    status_in = ~st;
    repeat (hold) begin
      @(negedge clk);
      check("ack_hold", 32'(m_ack), 32'd1);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    check("ack_release", 32'(m_ack), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    cfgweb = 1'b0; cfgad = 2'd0; cfgd = 32'h0; status_in = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cfg1", c1_a, 32'h0);
    check("rst_cfg2", c2_a, A_CFG2_RST);
    check("rst_cfg3", c3_a, 32'h0);
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_q", q_a, 32'h0);
    check("rst_b_cfg1", c1_b, B_CFG1_RST);

    txn(1'b0, 1'b0, 2'd3, 32'hDEAD_BEEF, 32'h0, 0);
    txn(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 1);
    txn(1'b0, 1'b1, 2'd0, 32'h0, 32'h0000_0001, 3);
    txn(1'b0, 1'b0, 2'd0, 32'h1234_5678, 32'h0, 0);
    txn(1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 10);
    txn(1'b0, 1'b0, 2'd1, 32'hCAFE_0001, 32'h0, 0);

    // Reset during WAIT of a write to address 1 discards it.
    sel = 1'b0; cfgweb = 1'b0; cfgad = 2'd1; cfgd = 32'h5555_AAAA; req_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    check("midrst_cfg1", c1_a, 32'h0);
    check("midrst_ack", 32'(ack_a), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("postrst_cfg1", c1_a, 32'h0);
    check("postrst_ack", 32'(ack_a), 32'd0);
    txn(1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 0);

    txn(1'b1, 1'b0, 2'd2, 32'h0BAD_F00D, 32'h0, 0);
    txn(1'b1, 1'b1, 2'd2, 32'h0, 32'h0, 2);
    txn(1'b1, 1'b1, 2'd1, 32'h0, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
          int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
